mo_linebuf: RTL and testbench

Double-buffered motion-object line buffer sitting directly downstream of the graphics cartridge shifters. It captures the 7-bit serialized motion-object pixel stream (MOSR) at horizontal positions set by the motion-object processor while the previous line is read out. Readout is merged with the cartridge's 8-bit playfield pixel stream (PFSR) by a priority mux, producing the palette index for the colour RAM.

---
 rtl/gfx_pkg.sv | 14 +
 rtl/lb_ram.sv | 27 ++
 rtl/mo_linebuf.sv | 166 ++++++++++++++++
 tb/tb_mo_linebuf.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/gfx_pkg.sv
// Shared types and defaults for the motion-object line buffer.
package gfx_pkg;

    localparam int unsigned XW_DEF     = 9;
    localparam logic [5:0]  TRANSP_DEF = 6'h00;

    typedef logic [6:0] mo_pix_t;

    typedef enum logic {
        CLEAR,
        RUN
    } lb_state_t;

endpackage

// File: rtl/lb_ram.sv
// One line-buffer bank: synchronous read port plus independent write port.
module lb_ram
    import gfx_pkg::*;
#(
    parameter int unsigned AW = XW_DEF
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  mo_pix_t       wdata,
    input  logic [AW-1:0] raddr,
    output mo_pix_t       rdata
);

    localparam int unsigned DEPTH = 1 << AW;

    mo_pix_t mem [DEPTH];

    // Read returns the pre-write contents when both ports hit one address.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/mo_linebuf.sv
// Double-buffered motion-object line buffer with playfield priority mux.
module mo_linebuf
    import gfx_pkg::*;
#(
    parameter int unsigned XW     = XW_DEF,
    parameter logic [5:0]  TRANSP = TRANSP_DEF
) (
    input  logic          sysclk,
    input  logic          reset_b,
    input  logic          line_start,
    input  logic          mo_load,
    input  logic [XW-1:0] mo_hpos,
    input  logic          mo_valid,
    input  mo_pix_t       MOSR,
    input  logic          pix_en,
    input  logic [7:0]    PFSR,
    output logic          ready,
    output logic [8:0]    color,
    output logic          color_valid,
    output logic          collide
);

    localparam logic [XW-1:0] XMAX  = {XW{1'b1}};
    localparam mo_pix_t       BLANK = {1'b0, TRANSP};

    lb_state_t     state;
    logic [XW-1:0] clr_ptr, wr_ptr, rd_ptr;
    logic          bank_sel, wr_done;
    logic          w1_valid, w1_bank, lw_valid, lw_bank;
    logic [XW-1:0] w1_addr, lw_addr;
    mo_pix_t       w1_data;
    logic          r1_valid, r1_bank;
    logic [XW-1:0] r1_addr;
    logic [7:0]    r1_pf;

    logic          run_c, bsel_c, wr_go_c, hit_c, commit_c, show_mo_c;
    logic [XW-1:0] wa_c, ra_c;
    mo_pix_t       w1_old_c, r1_pix_c;
    logic          ram_we_c    [2];
    logic [XW-1:0] ram_waddr_c [2];
    logic [XW-1:0] ram_raddr_c [2];
    mo_pix_t       ram_wdata_c [2];
    mo_pix_t       rdata       [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        lb_ram #(.AW(XW)) u_ram (
            .clk   (sysclk),
            .we    (ram_we_c[b]),
            .waddr (ram_waddr_c[b]),
            .wdata (ram_wdata_c[b]),
            .raddr (ram_raddr_c[b]),
            .rdata (rdata[b])
        );
    end

    // Bank steering; bsel_c already reflects a same-cycle line_start swap.
    always_comb begin
        run_c     = (state == RUN);
        bsel_c    = bank_sel ^ line_start;
        wa_c      = mo_load ? mo_hpos : wr_ptr;
        ra_c      = line_start ? '0 : rd_ptr;
        wr_go_c   = run_c && mo_valid && (mo_load || !wr_done);
        w1_old_c  = rdata[w1_bank];
        hit_c     = (w1_old_c[5:0] != TRANSP)
                  || (lw_valid && (lw_bank == w1_bank) && (lw_addr == w1_addr));
        commit_c  = w1_valid && !hit_c;
        r1_pix_c  = rdata[r1_bank];
        show_mo_c = (r1_pix_c[5:0] != TRANSP) && !(r1_pf[7] && (r1_pf[5:0] != 6'h00));
        for (int b = 0; b < 2; b++) begin
            ram_raddr_c[b] = (bsel_c == 1'(b)) ? wa_c : ra_c;
            ram_we_c[b]    = 1'b0;
            ram_waddr_c[b] = '0;
            ram_wdata_c[b] = BLANK;
            if (!run_c) begin
                ram_we_c[b]    = 1'b1;
                ram_waddr_c[b] = clr_ptr;
            end else if (commit_c && (w1_bank == 1'(b))) begin
                ram_we_c[b]    = 1'b1;
                ram_waddr_c[b] = w1_addr;
                ram_wdata_c[b] = w1_data;
            end else if (r1_valid && (r1_bank == 1'(b))) begin
                ram_we_c[b]    = 1'b1;
                ram_waddr_c[b] = r1_addr;
            end
        end
    end

    always_ff @(posedge sysclk or negedge reset_b) begin
        if (!reset_b) begin
            state       <= CLEAR;
            clr_ptr     <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            bank_sel    <= 1'b0;
            wr_done     <= 1'b1;
            w1_valid    <= 1'b0;
            w1_bank     <= 1'b0;
            w1_addr     <= '0;
            w1_data     <= '0;
            lw_valid    <= 1'b0;
            lw_bank     <= 1'b0;
            lw_addr     <= '0;
            r1_valid    <= 1'b0;
            r1_bank     <= 1'b0;
            r1_addr     <= '0;
            r1_pf       <= '0;
            ready       <= 1'b0;
            color       <= '0;
            color_valid <= 1'b0;
            collide     <= 1'b0;
        end else begin
            w1_valid    <= 1'b0;
            r1_valid    <= 1'b0;
            color_valid <= 1'b0;
            lw_valid    <= commit_c;
            lw_addr     <= w1_addr;
            lw_bank     <= w1_bank;
            case (state)
                CLEAR: begin
                    clr_ptr <= clr_ptr + 1'b1;
                    if (clr_ptr == XMAX) begin
                        state <= RUN;
                        ready <= 1'b1;
                    end
                end
                RUN: begin
                    if (line_start) begin
                        bank_sel <= ~bank_sel;
                        collide  <= 1'b0;
                    end
                    if (w1_valid && hit_c) begin
                        collide <= 1'b1;
                    end
                    if (mo_load) begin
                        wr_ptr  <= mo_hpos;
                        wr_done <= 1'b0;
                    end
                    // No wrap: the last column closes the object until the next load.
                    if (wr_go_c) begin
                        wr_ptr   <= wa_c + 1'b1;
                        wr_done  <= (wa_c == XMAX);
                        w1_valid <= (MOSR[5:0] != TRANSP);
                        w1_addr  <= wa_c;
                        w1_data  <= MOSR;
                        w1_bank  <= bsel_c;
                    end
                    if (pix_en) begin
                        rd_ptr   <= ra_c + 1'b1;
                        r1_valid <= 1'b1;
                        r1_addr  <= ra_c;
                        r1_bank  <= ~bsel_c;
                        r1_pf    <= PFSR;
                    end else if (line_start) begin
                        rd_ptr <= '0;
                    end
                    if (r1_valid) begin
                        color_valid <= 1'b1;
                        color       <= show_mo_c ? {2'b10, r1_pix_c} : {1'b0, r1_pf};
                    end
                end
                default: state <= CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_mo_linebuf.sv
// Directed self-checking bench for mo_linebuf with hand-computed line images.
`timescale 1ns/1ps
module tb_mo_linebuf;

    logic       sysclk = 1'b0;
    logic       reset_b = 1'b0;
    logic       line_start = 1'b0;
    logic       mo_load = 1'b0;
    logic [8:0] mo_hpos = '0;
    logic       mo_valid = 1'b0;
    logic [6:0] MOSR = '0;
    logic       pix_en = 1'b0;
    logic [7:0] PFSR = '0;
    logic       ready;
    logic [8:0] color;
    logic       color_valid;
    logic       collide;

    int n_checks = 0;
    int n_errors = 0;

    logic [8:0] exp_line [512];
    logic [7:0] pf_line  [512];

    mo_linebuf dut (
        .sysclk      (sysclk),
        .reset_b     (reset_b),
        .line_start  (line_start),
        .mo_load     (mo_load),
        .mo_hpos     (mo_hpos),
        .mo_valid    (mo_valid),
        .MOSR        (MOSR),
        .pix_en      (pix_en),
        .PFSR        (PFSR),
        .ready       (ready),
        .color       (color),
        .color_valid (color_valid),
        .collide     (collide)
    );

    always #5 sysclk = ~sysclk;

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic fill_line(input logic [7:0] pf);
        for (int i = 0; i < 512; i++) begin
            pf_line[i]  = pf;
            exp_line[i] = {1'b0, pf};
        end
    endtask

    // Waits for the clear sweep; ready must rise exactly 512 cycles after release.
    task automatic release_and_sweep(input string tag);
        int  cnt;
        bit  dirty;
        cnt   = 0;
        dirty = 1'b0;
        @(negedge sysclk);
        reset_b = 1'b1;
        while (!ready && cnt < 1000) begin
            @(negedge sysclk);
            cnt++;
            if (color !== 9'h000 || collide !== 1'b0) dirty = 1'b1;
        end
        check({tag, "_sweep_len"}, 16'(cnt), 16'd512);
        check({tag, "_sweep_quiet"}, 16'(dirty), 16'd0);
    endtask

    task automatic write_obj(input logic [8:0] x, input int n, input logic [6:0] first,
                             input int step, input bit sep);
        @(negedge sysclk);
        mo_load  = 1'b1;
        mo_hpos  = x;
        mo_valid = !sep;
        MOSR     = first;
        if (sep) begin
            @(negedge sysclk);
            mo_load  = 1'b0;
            mo_valid = 1'b1;
        end
        for (int i = 1; i < n; i++) begin
            @(negedge sysclk);
            mo_load  = 1'b0;
            mo_valid = 1'b1;
            MOSR     = first + 7'(i * step);
        end
        @(negedge sysclk);
        mo_load  = 1'b0;
        mo_valid = 1'b0;
    endtask

    // Starts a line, issues n pix_en and compares each output two cycles later.
    task automatic read_line(input string tag, input int n);
        @(negedge sysclk);
        line_start = 1'b1;
        pix_en     = 1'b0;
        @(negedge sysclk);
        line_start = 1'b0;
        for (int i = 0; i < n + 2; i++) begin
            if (i >= 2) begin
                check($sformatf("%s[%0d]", tag, i - 2), {6'd0, color_valid, color},
                      {6'd0, 1'b1, exp_line[i - 2]});
            end
            pix_en = (i < n);
            PFSR   = (i < n) ? pf_line[i] : 8'h00;
            @(negedge sysclk);
        end
        pix_en = 1'b0;
    endtask

    initial begin
        // 1: reset state and clear sweep
        repeat (3) @(negedge sysclk);
        check("rst_ready", 16'(ready), 16'd0);
        check("rst_color", 16'(color), 16'h000);
        check("rst_valid", 16'(color_valid), 16'd0);
        check("rst_collide", 16'(collide), 16'd0);
        release_and_sweep("init");

        // 2: basic write, readout, then erase proven on the same bank two lines later
        write_obj(9'd100, 16, 7'h41, 1, 1'b1);
        fill_line(8'h05);
        for (int i = 0; i < 16; i++) exp_line[100 + i] = 9'h141 + 9'(i);
        read_line("basic", 200);
        fill_line(8'h05);
        read_line("other_bank", 200);
        read_line("erased", 200);

        // 3: edge of line, then a stray pixel with wr_done set
        write_obj(9'd508, 8, 7'h01, 1, 1'b0);
        @(negedge sysclk);
        mo_valid = 1'b1;
        MOSR     = 7'h33;
        @(negedge sysclk);
        mo_valid = 1'b0;
        fill_line(8'h00);
        for (int i = 0; i < 4; i++) exp_line[508 + i] = 9'h101 + 9'(i);
        read_line("edge", 512);

        // 4: collision, spaced and back-to-back at the same address
        check("collide_pre", 16'(collide), 16'd0);
        write_obj(9'd50, 1, 7'h11, 0, 1'b0);
        write_obj(9'd50, 1, 7'h22, 0, 1'b0);
        @(negedge sysclk);
        check("collide_set", 16'(collide), 16'd1);
        @(negedge sysclk);
        mo_load = 1'b1; mo_hpos = 9'd60; mo_valid = 1'b1; MOSR = 7'h11;
        @(negedge sysclk);
        MOSR = 7'h22;
        @(negedge sysclk);
        mo_load = 1'b0; mo_valid = 1'b0;
        repeat (3) @(negedge sysclk);
        check("collide_hold", 16'(collide), 16'd1);
        fill_line(8'h00);
        exp_line[50] = 9'h111;
        exp_line[60] = 9'h111;
        read_line("collide", 512);
        check("collide_clr", 16'(collide), 16'd0);

        // 5: priority mux against playfield priority bit
        write_obj(9'd10, 3, 7'h0A, 0, 1'b0);
        fill_line(8'h00);
        pf_line[10] = 8'h83; exp_line[10] = 9'h083;
        pf_line[11] = 8'h80; exp_line[11] = 9'h10A;
        pf_line[12] = 8'h03; exp_line[12] = 9'h10A;
        pf_line[13] = 8'h83; exp_line[13] = 9'h083;
        read_line("prio", 512);

        // 6a: line_start with mo_valid lands in the new write bank
        @(negedge sysclk);
        line_start = 1'b1; mo_load = 1'b1; mo_hpos = 9'd20; mo_valid = 1'b1; MOSR = 7'h55;
        @(negedge sysclk);
        line_start = 1'b0; mo_load = 1'b0; mo_valid = 1'b0;
        fill_line(8'h00);
        exp_line[20] = 9'h155;
        read_line("simul_wr", 512);

        // 6b: line_start with pix_en reads address 0 of the new read bank
        write_obj(9'd0, 1, 7'h66, 0, 1'b0);
        @(negedge sysclk);
        line_start = 1'b1; pix_en = 1'b1; PFSR = 8'h00;
        @(negedge sysclk);
        line_start = 1'b0; pix_en = 1'b0;
        @(negedge sysclk);
        check("simul_rd", {6'd0, color_valid, color}, {6'd0, 1'b1, 9'h166});

        // 6c: mid-line reset wipes both banks
        write_obj(9'd30, 1, 7'h77, 0, 1'b0);
        @(negedge sysclk);
        line_start = 1'b1;
        @(negedge sysclk);
        line_start = 1'b0; pix_en = 1'b1;
        repeat (5) @(negedge sysclk);
        reset_b = 1'b0; pix_en = 1'b0;
        @(negedge sysclk);
        check("mid_rst_ready", 16'(ready), 16'd0);
        check("mid_rst_color", 16'(color), 16'h000);
        release_and_sweep("mid");
        fill_line(8'h05);
        read_line("post_rst_a", 512);
        read_line("post_rst_b", 512);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
